// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch stage. Core-level debug logic
//   and future CSR cause encoding reference the fetch state encoding and the
//   reset-time instruction word from here.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  // Fetch sequencer states. The encoding is fixed so that debug views of the
  // state bits stay meaningful across revisions.
  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_RESP  = 3'd3,
    FS_FAULT = 3'd4
  } fetch_state_t;

  // addi x0,x0,0: a harmless word to present before the first fetch lands.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of a counter that must hold 0 .. timeout-1 and still have headroom
  // to saturate rather than wrap.
  function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage directly upstream of the core. Watches the core pc,
//   issues single-beat reads on a request/grant/response bus, and presents the
//   returned word with a one-cycle instr_valid pulse. Responses that arrive
//   after the pc has moved are dropped. Bus errors, misaligned pc and response
//   timeouts park the block in a fault state until the pc is redirected.
//
// Ports
//   clock        : system clock, all state on the rising edge
//   reset        : asynchronous active-low reset
//   pc           : current core pc
//   instruction  : fetched word, registered, held between responses
//   instr_valid  : one-cycle pulse, instruction belongs to the current pc
//   fetch_fault  : high while the block sits in FAULT
//   ibus_req     : read request, held until ibus_gnt
//   ibus_addr    : word address of the request (tracks pc)
//   ibus_gnt     : request accepted this cycle
//   ibus_rvalid  : response valid
//   ibus_rdata   : response data
//   ibus_err     : response error, qualified by ibus_rvalid
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before a timeout fault (>= 2)
//   NOP_INSTR      : value of instruction out of reset
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NOP_INSTR      = instr_fetch_pkg::NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err
);

  import instr_fetch_pkg::*;

  localparam int unsigned      CNT_W    = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fetch_state_t     r_state;
  logic [31:0]      r_instruction;
  logic [31:0]      r_inflight_addr;
  logic [31:0]      r_faulted_addr;
  logic [CNT_W-1:0] r_cnt;

  logic w_misaligned;
  logic w_pc_is_inflight;

  assign w_misaligned     = (pc[1:0] != 2'b00);
  assign w_pc_is_inflight = (pc == r_inflight_addr);

  // Outputs are pure decodes of the registered state. Where they also look at
  // pc it is because the decision genuinely depends on the pc of this cycle:
  // a misaligned pc must never reach the bus, and a redirect that lands on the
  // RESP cycle must suppress the pulse.
  assign ibus_req    = (r_state == FS_REQ) && !w_misaligned;
  assign ibus_addr   = pc;
  assign instr_valid = (r_state == FS_RESP) && w_pc_is_inflight;
  assign fetch_fault = (r_state == FS_FAULT);
  assign instruction = r_instruction;

  // NOTE: every register here, datapath included, is cleared by the async
  // reset and updated with non-blocking assignments so all of them sample the
  // same pre-edge values; the bus shares this reset, so an aborted read leaves
  // nothing to track afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= FS_IDLE;
      r_instruction   <= NOP_INSTR;
      r_inflight_addr <= '0;
      r_faulted_addr  <= '0;
      r_cnt           <= '0;
    end else begin
      case (r_state)
        // One settling cycle after reset release before the first request.
        FS_IDLE: r_state <= FS_REQ;

        FS_REQ: begin
          if (w_misaligned) begin
            r_faulted_addr <= pc;
            r_state        <= FS_FAULT;
          end else if (ibus_gnt) begin
            r_inflight_addr <= pc;
            r_cnt           <= '0;
            r_state         <= FS_WAIT;
          end
        end

        FS_WAIT: begin
          if (ibus_rvalid) begin
            if (!w_pc_is_inflight) begin
              // Core moved on while the read was out: drop it, error included.
              r_state <= FS_REQ;
            end else if (ibus_err) begin
              r_faulted_addr <= pc;
              r_state        <= FS_FAULT;
            end else begin
              r_instruction <= ibus_rdata;
              r_state       <= FS_RESP;
            end
          end else if (r_cnt >= CNT_LAST) begin
            // A response arriving in the last allowed cycle still wins above.
            r_faulted_addr <= pc;
            r_state        <= FS_FAULT;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        FS_RESP: r_state <= FS_REQ;

        // Only a trap redirect (any pc change) releases the fault.
        FS_FAULT: begin
          if (pc != r_faulted_addr) begin
            r_state <= FS_REQ;
          end
        end

        default: r_state <= FS_IDLE;
      endcase
    end
  end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. The stimulus process plays both the core
//   (pc) and the instruction bus, pushing the response it expects into a
//   scoreboard queue. An independent monitor pops the queue whenever the DUT
//   pulses instr_valid or raises fetch_fault. Inputs change 1 ns after the
//   rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        is_fault;
    logic [31:0] word;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h8000_0000;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_fault;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = '0;
  logic        ibus_err = 1'b0;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_instr = NOP;

  instr_fetch #(
    .TIMEOUT_CYCLES(TO),
    .NOP_INSTR     (NOP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .fetch_fault(fetch_fault),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_gnt   (ibus_gnt),
    .ibus_rvalid(ibus_rvalid),
    .ibus_rdata (ibus_rdata),
    .ibus_err   (ibus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops one expectation per instr_valid pulse or fault rise.
  initial begin : monitor
    logic prev_fault;
    exp_t e;
    prev_fault = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_valid || (fetch_fault && !prev_fault)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: valid=%b fault=%b instr=%h", instr_valid,
                   fetch_fault, instruction);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_is_fault", {31'd0, fetch_fault}, {31'd0, e.is_fault});
          check("event_valid", {31'd0, instr_valid}, {31'd0, !e.is_fault});
          check("event_instruction", instruction, e.word);
        end
      end
      if (ibus_req) check("mon_addr_eq_pc", ibus_addr, pc);
      prev_fault = fetch_fault;
    end
  end

  // Runs one read from a REQ cycle with pc==addr already set. gnt comes after
  // gnt_wait idle REQ cycles; rvalid arrives in WAIT cycle number rv_wait.
  // Returns one cycle into RESP (or FAULT when err is set).
  task automatic run_fetch(input logic [31:0] addr, input int gnt_wait, input int rv_wait,
                           input logic [31:0] data, input logic err);
    exp_t e;
    for (int i = 0; i < gnt_wait; i++) begin
      check("req_held", {31'd0, ibus_req}, 32'd1);
      check("req_addr", ibus_addr, addr);
      cyc();
    end
    check("req_at_gnt", {31'd0, ibus_req}, 32'd1);
    check("req_addr_at_gnt", ibus_addr, addr);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    for (int i = 1; i < rv_wait; i++) begin
      check("req_low_in_wait", {31'd0, ibus_req}, 32'd0);
      check("no_valid_in_wait", {31'd0, instr_valid}, 32'd0);
      check("instr_hold_in_wait", instruction, last_instr);
      cyc();
    end
    check("req_low_in_wait", {31'd0, ibus_req}, 32'd0);
    ibus_rvalid = 1'b1;
    ibus_rdata  = data;
    ibus_err    = err;
    if (!err) last_instr = data;
    e.is_fault = err;
    e.word     = last_instr;
    exp_q.push_back(e);
    cyc();
    ibus_rvalid = 1'b0;
    ibus_err    = 1'b0;
    ibus_rdata  = 32'hFFFF_FFFF;
    if (err) begin
      check("err_fault", {31'd0, fetch_fault}, 32'd1);
      check("err_no_valid", {31'd0, instr_valid}, 32'd0);
      check("err_instr_kept", instruction, last_instr);
    end else begin
      check("resp_valid", {31'd0, instr_valid}, 32'd1);
      check("resp_instr", instruction, data);
    end
  endtask

  // From RESP: no new request during RESP, then the core advances pc as the
  // state returns to REQ.
  task automatic next_req(input logic [31:0] new_pc);
    check("no_req_in_resp", {31'd0, ibus_req}, 32'd0);
    cyc();
    pc = new_pc;
    #1;
    check("no_valid_after_resp", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin : stimulus
    exp_t e;

    // Reset state.
    repeat (3) cyc();
    check("rst_instr", instruction, NOP);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, ibus_req}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // Best case: IDLE one cycle, then REQ/WAIT/RESP.
    reset = 1'b1;
    #1;
    check("idle_no_req", {31'd0, ibus_req}, 32'd0);
    cyc();
    run_fetch(32'h8000_0000, 0, 1, 32'h0010_0093, 1'b0);

    // pc moves during WAIT: stale response (with err) is dropped.
    next_req(32'h8000_0004);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    pc = 32'h8000_0100;
    cyc();
    ibus_rvalid = 1'b1;
    ibus_rdata  = 32'hDEAD_BEEF;
    ibus_err    = 1'b1;
    cyc();
    ibus_rvalid = 1'b0;
    ibus_err    = 1'b0;
    check("discard_no_fault", {31'd0, fetch_fault}, 32'd0);
    check("discard_no_valid", {31'd0, instr_valid}, 32'd0);
    check("discard_instr_kept", instruction, last_instr);
    check("rereq", {31'd0, ibus_req}, 32'd1);
    check("rereq_addr", ibus_addr, 32'h8000_0100);
    run_fetch(32'h8000_0100, 0, 1, 32'h0000_0513, 1'b0);

    // Slow grant (req high 4 cycles) and slow response (5 cycles after gnt).
    next_req(32'h8000_0104);
    run_fetch(32'h8000_0104, 3, 5, 32'h0050_0593, 1'b0);

    // Bus error: fault sticks while pc is unchanged, clears on redirect.
    next_req(32'h8000_0008);
    run_fetch(32'h8000_0008, 1, 2, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      check("fault_no_req", {31'd0, ibus_req}, 32'd0);
    end
    pc = 32'h8000_0200;
    cyc();
    check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    check("redirect_req", {31'd0, ibus_req}, 32'd1);
    run_fetch(32'h8000_0200, 0, 1, 32'h0020_0113, 1'b0);

    // Response in the last allowed WAIT cycle is still accepted.
    next_req(32'h8000_0204);
    run_fetch(32'h8000_0204, 0, TO, 32'h0030_0193, 1'b0);

    // Timeout: fault exactly after TO silent WAIT cycles; late rvalid ignored.
    next_req(32'h8000_0300);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    for (int i = 1; i < TO; i++) begin
      check("no_early_timeout", {31'd0, fetch_fault}, 32'd0);
      cyc();
    end
    check("no_early_timeout", {31'd0, fetch_fault}, 32'd0);
    e.is_fault = 1'b1;
    e.word     = last_instr;
    exp_q.push_back(e);
    cyc();
    check("timeout_fault", {31'd0, fetch_fault}, 32'd1);
    ibus_rvalid = 1'b1;
    ibus_rdata  = 32'hBAD0_0000;
    cyc();
    ibus_rvalid = 1'b0;
    check("late_rvalid_fault", {31'd0, fetch_fault}, 32'd1);
    check("late_rvalid_instr", instruction, last_instr);

    // Redirect to a misaligned pc: straight to FAULT, no request.
    pc = 32'h8000_0002;
    cyc();
    check("misaligned_no_req", {31'd0, ibus_req}, 32'd0);
    check("misaligned_req_state", {31'd0, fetch_fault}, 32'd0);
    e.is_fault = 1'b1;
    e.word     = last_instr;
    exp_q.push_back(e);
    #4;
    check("misaligned_no_req_mid", {31'd0, ibus_req}, 32'd0);
    cyc();
    check("misaligned_fault", {31'd0, fetch_fault}, 32'd1);
    check("misaligned_fault_no_req", {31'd0, ibus_req}, 32'd0);

    // Async reset in the middle of WAIT.
    pc = 32'h8000_0400;
    cyc();
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    cyc();
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_instr", instruction, NOP);
    check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("async_rst_req", {31'd0, ibus_req}, 32'd0);
    check("async_rst_fault", {31'd0, fetch_fault}, 32'd0);
    last_instr = NOP;
    cyc();
    reset = 1'b1;
    #1;
    check("rerelease_idle", {31'd0, ibus_req}, 32'd0);
    cyc();
    run_fetch(32'h8000_0400, 2, 3, 32'h0040_0213, 1'b0);
    next_req(32'h8000_0404);

    repeat (2) cyc();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
